// File: rtl/fir_coeff_reg_bridge.sv
// Host register front end for fir_coeff_master: staging words, CTRL/STATUS, req/ack handshake with timeout.
// Optional FIR_COEFF_AUTO_READBACK_EN: every completed write is followed by a verifying read.
module fir_coeff_reg_bridge #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [3:0]   host_addr,
  input  logic         host_wr,
  input  logic         host_rd,
  input  logic [31:0]  host_wr_data,
  output logic [31:0]  host_rd_data,
  output logic         host_rd_valid,
  output logic         req,
  output logic         wr_op,
  input  logic         ack,
  output logic [127:0] coeff_wr_data,
  input  logic [127:0] coeff_rd_data
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;

  state_t            state, state_nxt;
  logic [3:0][31:0]  stage, rbk;
  logic [CW-1:0]     cnt;
  logic              done, timeout, err, mismatch, busy;
  logic              wr_stage, wr_ctrl, wr_stat, start, timed_out, rel_done, chain;
  logic [31:0]       rd_mux;

  assign wr_stage      = host_wr && (host_addr[3:2] == 2'b00);
  assign wr_ctrl       = host_wr && (host_addr == 4'd8);
  assign wr_stat       = host_wr && (host_addr == 4'd9);
  assign start         = wr_ctrl && !busy && (host_wr_data[0] || host_wr_data[1]);
  assign timed_out     = (state == S_REQ) && !ack && (cnt == CNT_LAST);
  assign rel_done      = (state == S_REL) && !ack;
  assign coeff_wr_data = stage;

`ifdef FIR_COEFF_AUTO_READBACK_EN
  logic aborted, auto_rd;

  // A timed-out write must not trigger the follow-up read.
  assign chain = rel_done && wr_op && !aborted;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aborted  <= 1'b0;
      auto_rd  <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      if (start) begin
        aborted <= 1'b0;
        auto_rd <= 1'b0;
      end else begin
        if (timed_out) aborted <= 1'b1;
        if (chain)     auto_rd <= 1'b1;
      end
      if ((state == S_REQ) && ack && auto_rd && (coeff_rd_data != stage))
        mismatch <= 1'b1;
      else if (wr_stat && host_wr_data[4])
        mismatch <= 1'b0;
    end
  end
`else
  assign chain    = 1'b0;
  assign mismatch = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_REQ;
      S_REQ:   if (ack || timed_out) state_nxt = S_REL;
      S_REL:   if (chain) state_nxt = S_REQ;
               else if (rel_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req  = (state == S_REQ);
    busy = (state != S_IDLE);
  end

  always_comb begin
    rd_mux = 32'd0;
    if (host_addr[3:2] == 2'b00)      rd_mux = stage[host_addr[1:0]];
    else if (host_addr[3:2] == 2'b01) rd_mux = rbk[host_addr[1:0]];
    else if (host_addr == 4'd9)       rd_mux = {27'd0, mismatch, err, timeout, done, busy};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage         <= '0;
      rbk           <= '0;
      wr_op         <= 1'b0;
      cnt           <= '0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      err           <= 1'b0;
      host_rd_data  <= 32'd0;
      host_rd_valid <= 1'b0;
    end else begin
      if (wr_stage && !busy) stage[host_addr[1:0]] <= host_wr_data;

      if (start) begin
        wr_op <= host_wr_data[0];
        cnt   <= '0;
      end else if (chain) begin
        wr_op <= 1'b0;
        cnt   <= '0;
      end else if ((state == S_REQ) && !ack) begin
        cnt <= cnt + 1'b1;
      end

      if ((state == S_REQ) && ack && !wr_op) rbk <= coeff_rd_data;

      // Hardware set has priority over the host's write-1-to-clear.
      if (rel_done && !chain)              done <= 1'b1;
      else if (wr_stat && host_wr_data[1]) done <= 1'b0;
      if (timed_out)                       timeout <= 1'b1;
      else if (wr_stat && host_wr_data[2]) timeout <= 1'b0;
      if (busy && (wr_stage || wr_ctrl))   err <= 1'b1;
      else if (wr_stat && host_wr_data[3]) err <= 1'b0;

      host_rd_valid <= host_rd;
      if (host_rd) host_rd_data <= rd_mux;
    end
  end
endmodule

// File: tb/tb_fir_coeff_reg_bridge.sv
// Bench for fir_coeff_reg_bridge: directed scenarios plus randomized host traffic against a behavioural model.
module tb_fir_coeff_reg_bridge;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   host_addr = '0;
  logic         host_wr = 1'b0;
  logic         host_rd = 1'b0;
  logic [31:0]  host_wr_data = '0;
  logic [31:0]  host_rd_data;
  logic         host_rd_valid;
  logic         req;
  logic         wr_op;
  logic         ack = 1'b0;
  logic [127:0] coeff_wr_data;
  logic [127:0] coeff_rd_data = '0;

  always #5 clk = ~clk;

  fir_coeff_reg_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .host_addr(host_addr), .host_wr(host_wr), .host_rd(host_rd),
    .host_wr_data(host_wr_data), .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid),
    .req(req), .wr_op(wr_op), .ack(ack), .coeff_wr_data(coeff_wr_data), .coeff_rd_data(coeff_rd_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Behavioural model: what the host and the coefficient master should observe.
  bit [31:0] m_stage[4];
  bit [31:0] m_rbk[4];
  bit        m_req, m_rel, m_wr_op, m_done, m_to, m_err, m_mm, m_auto, m_abort;
  int        m_held;
  bit        m_rd_valid;
  bit [31:0] m_rd_data;

  function automatic bit [31:0] m_read(input logic [3:0] a);
    if (a < 4)  return m_stage[a[1:0]];
    if (a < 8)  return m_rbk[a[1:0]];
    if (a == 9) return {27'd0, m_mm, m_err, m_to, m_done, (m_req || m_rel)};
    return 32'd0;
  endfunction

  task automatic model_step();
    bit busy, go_wr, go_rd;
    busy  = m_req || m_rel;
    go_wr = 0;
    go_rd = 0;
    m_rd_valid = host_rd;
    if (host_rd) m_rd_data = m_read(host_addr);
    if (host_wr) begin
      if (host_addr < 4) begin
        if (busy) m_err = 1;
        else      m_stage[host_addr[1:0]] = host_wr_data;
      end else if (host_addr == 8) begin
        if (busy)                 m_err = 1;
        else if (host_wr_data[0]) go_wr = 1;
        else if (host_wr_data[1]) go_rd = 1;
      end else if (host_addr == 9) begin
        if (host_wr_data[1]) m_done = 0;
        if (host_wr_data[2]) m_to = 0;
        if (host_wr_data[3]) m_err = 0;
        if (host_wr_data[4]) m_mm = 0;
      end
    end
    if (m_req) begin
      if (ack) begin
        m_req = 0;
        m_rel = 1;
        if (!m_wr_op) begin
          for (int i = 0; i < 4; i++) m_rbk[i] = coeff_rd_data[32*i +: 32];
          if (m_auto && coeff_rd_data != {m_stage[3], m_stage[2], m_stage[1], m_stage[0]}) m_mm = 1;
        end
      end else begin
        m_held++;
        if (m_held == T) begin
          m_req   = 0;
          m_rel   = 1;
          m_to    = 1;
          m_abort = 1;
        end
      end
    end else if (m_rel) begin
      if (!ack) begin
        m_rel = 0;
`ifdef FIR_COEFF_AUTO_READBACK_EN
        if (m_wr_op && !m_abort) begin
          m_req   = 1;
          m_wr_op = 0;
          m_held  = 0;
          m_auto  = 1;
        end else m_done = 1;
`else
        m_done = 1;
`endif
      end
    end else if (go_wr || go_rd) begin
      m_req   = 1;
      m_wr_op = go_wr;
      m_held  = 0;
      m_abort = 0;
      m_auto  = 0;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        m_stage[i] = 0;
        m_rbk[i]   = 0;
      end
      {m_req, m_rel, m_wr_op, m_done, m_to, m_err, m_mm, m_auto, m_abort} = '0;
      m_held     = 0;
      m_rd_valid = 0;
      m_rd_data  = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("req", req, m_req);
      check("wr_op", wr_op, m_wr_op);
      check("coeff_wr_data", coeff_wr_data, {m_stage[3], m_stage[2], m_stage[1], m_stage[0]});
      check("host_rd_valid", host_rd_valid, m_rd_valid);
      if (m_rd_valid) check("host_rd_data", host_rd_data, m_rd_data);
    end
  end

  // Coefficient-master stand-in.
  bit           resp_en = 1, resp_spur = 0, resp_rand = 0;
  int           resp_dmin = 0, resp_dmax = 0;
  logic [127:0] resp_data = '0;

  initial begin
    int dly;
    forever begin
      @(negedge clk);
      if (req && resp_en) begin
        dly = $urandom_range(resp_dmax, resp_dmin);
        repeat (dly) @(negedge clk);
        coeff_rd_data = resp_rand ? {$urandom, $urandom, $urandom, $urandom} : resp_data;
        ack = 1'b1;
        for (int i = 0; i < 40 && req; i++) @(negedge clk);
        repeat ($urandom_range(2, 0)) @(negedge clk);
        ack = 1'b0;
      end else begin
        ack = resp_spur;
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    host_addr    = a;
    host_wr_data = d;
    host_wr      = 1'b1;
    @(negedge clk);
    host_wr = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    host_addr = a;
    host_rd   = 1'b1;
    @(negedge clk);
    host_rd = 1'b0;
    d = host_rd_data;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check({name, "_valid"}, host_rd_valid, 1'b1);
    check(name, d, exp);
  endtask

  task automatic wait_req(input logic lvl, input int budget, input string name);
    for (int i = 0; i < budget && req !== lvl; i++) @(negedge clk);
    check(name, req, lvl);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] d;
    d = 32'd1;
    for (int i = 0; i < 200 && d[0]; i++) rd(4'd9, d);
    check(name, d[0], 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          cnt;

    // Reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("reset_req", req, 1'b0);
    rd_chk("reset_status", 4'd9, 32'h0);
    for (int i = 0; i < 4; i++) rd_chk("reset_rbk", 4'(4 + i), 32'h0);

    // Write op with known staging words, ack after 10 cycles
    wr(4'd0, 32'h11223344);
    wr(4'd1, 32'h55667788);
    wr(4'd2, 32'h99AABBCC);
    wr(4'd3, 32'hDDEEFF00);
    resp_dmin = 10;
    resp_dmax = 10;
    wr(4'd8, 32'h1);
    check("t2_req", req, 1'b1);
    check("t2_wr_op", wr_op, 1'b1);
    check("t2_coeff_wr_data", coeff_wr_data, 128'hDDEEFF0099AABBCC5566778811223344);
    wait_req(1'b0, 30, "t2_req_drop");
    wait_idle("t2_idle");
    rd_chk("t2_status", 4'd9, 32'h2);

    // Read op captures readback pattern
    wr(4'd9, 32'h1E);
    resp_data = 128'hA1B2C3D4_E5F60718_293A4B5C_6D7E8F90;
    resp_dmin = 3;
    resp_dmax = 3;
    wr(4'd8, 32'h2);
    check("t3_wr_op", wr_op, 1'b0);
    wait_idle("t3_idle");
    rd_chk("t3_rbk0", 4'd4, 32'h6D7E8F90);
    rd_chk("t3_rbk1", 4'd5, 32'h293A4B5C);
    rd_chk("t3_rbk2", 4'd6, 32'hE5F60718);
    rd_chk("t3_rbk3", 4'd7, 32'hA1B2C3D4);
    rd_chk("t3_status", 4'd9, 32'h2);

    // No ack: req held exactly TIMEOUT_CYCLES cycles
    wr(4'd9, 32'h1E);
    resp_en = 0;
    wr(4'd8, 32'h1);
    wait_req(1'b1, 5, "t4_req_rise");
    cnt = 0;
    while (req && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("t4_req_cycles", cnt, T);
    repeat (3) @(negedge clk);
    rd_chk("t4_status", 4'd9, 32'h6);
    wr(4'd9, 32'h4);
    rd_chk("t4_status_w1c", 4'd9, 32'h2);
    resp_en = 1;

    // Spurious ack while idle is ignored
    resp_spur = 1;
    repeat (5) @(negedge clk);
    check("spur_req", req, 1'b0);
    resp_spur = 0;
    repeat (2) @(negedge clk);

    // Writes while busy are dropped and flag err
    wr(4'd9, 32'h1E);
    resp_dmin = 8;
    resp_dmax = 8;
    wr(4'd8, 32'h1);
    wr(4'd0, 32'hDEADBEEF);
    wr(4'd8, 32'h3);
    wait_idle("t5_idle");
    repeat (4) @(negedge clk);
    check("t5_no_req", req, 1'b0);
    rd_chk("t5_stage0", 4'd0, 32'h11223344);
    rd_chk("t5_status", 4'd9, 32'hA);
    wr(4'd9, 32'h1E);
    resp_dmin = 2;
    resp_dmax = 2;
    wr(4'd8, 32'h3);
    check("t5_wr_op_both", wr_op, 1'b1);
    wait_idle("t5_idle2");

`ifdef FIR_COEFF_AUTO_READBACK_EN
    // Auto readback with altered word1
    wr(4'd9, 32'h1E);
    resp_data = 128'hDDEEFF00_99AABBCC_5566778F_11223344;
    resp_dmin = 6;
    resp_dmax = 6;
    wr(4'd8, 32'h1);
    wait_req(1'b0, 30, "t6_write_drop");
    wait_req(1'b1, 10, "t6_read_rise");
    check("t6_read_wr_op", wr_op, 1'b0);
    rd_chk("t6_status_mid", 4'd9, 32'h1);
    wait_idle("t6_idle");
    rd_chk("t6_status", 4'd9, 32'h12);
    rd_chk("t6_rbk1", 4'd5, 32'h5566778F);
`endif

    // Randomized host traffic with random ack delays (some beyond the timeout)
    resp_rand = 1;
    resp_dmin = 0;
    resp_dmax = 20;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(7, 0))
        0: wr(4'($urandom_range(3, 0)), $urandom);
        1, 2: wr(4'd8, 32'($urandom_range(3, 0)));
        3: wr(4'd9, $urandom);
        4: rd(4'($urandom_range(15, 0)), d);
        5: wr(4'($urandom_range(1, 0) ? $urandom_range(15, 10) : $urandom_range(7, 4)), $urandom);
        6: begin
          @(negedge clk);
          host_addr    = 4'($urandom_range(9, 0));
          host_wr_data = $urandom;
          host_wr      = 1'b1;
          host_rd      = 1'b1;
          @(negedge clk);
          host_wr = 1'b0;
          host_rd = 1'b0;
        end
        default: repeat ($urandom_range(6, 1)) @(negedge clk);
      endcase
    end
    resp_rand = 0;
    resp_dmax = 3;
    wait_idle("rand_idle");

    // Reset in the middle of an operation drops req at once
    resp_en = 0;
    wr(4'd8, 32'h2);
    wait_req(1'b1, 5, "rst_req_rise");
    #2 reset_n = 1'b0;
    #1 check("rst_req_async", req, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk("rst_status", 4'd9, 32'h0);
    rd_chk("rst_rbk0", 4'd4, 32'h0);
    rd_chk("rst_stage0", 4'd0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
